// File: rtl/fm_tuner_pkg.sv
// Shared types and constants for the FM tuner: FSM states, band limits, preset table
// and the wrapping step helper.
package fm_tuner_pkg;

  typedef enum logic [1:0] {StIdle, StMute, StTune, StSettle} state_e;

  // Frequencies are in 10 Hz units.
  localparam logic [31:0] FMinDef   = 32'd8750000;
  localparam logic [31:0] FMaxDef   = 32'd10800000;
  localparam logic [31:0] FStepDef  = 32'd10000;
  localparam logic [31:0] FResetDef = 32'd10000000;

  // Slot 0 is the least significant word.
  localparam logic [3:0][31:0] PresetReset = {32'd10800000, 32'd10000000,
                                              32'd9500000,  32'd8750000};

  // One channel step with wrap-around at either band edge.
  function automatic logic [31:0] step_freq(input logic [31:0] f, input logic up,
                                            input logic [31:0] f_min, input logic [31:0] f_max,
                                            input logic [31:0] f_step);
    logic [31:0] r;
    if (up) r = (f > f_max - f_step) ? f_min : f + f_step;
    else    r = (f < f_min + f_step) ? f_max : f - f_step;
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter and rising-edge detector.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [1:0]      sync_q;
  logic            level_q, level_d, press_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) level_d = sync_q[1];
      else                                     cnt_d   = cnt_q + 1'b1;
    end
  end

  // Level resets high so a button held through reset yields no edge until re-pressed.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_raw};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= level_d & ~level_q;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/fm_tuner.sv
// FM tuner front panel: debounced buttons drive a mute/retune/settle sequence that updates
// the transmitter carrier word, with four presets recalled or stored via the center key.
module fm_tuner
  import fm_tuner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned LONG_CYCLES     = 25000000,
  parameter int unsigned MUTE_CYCLES     = 25000,
  parameter int unsigned SETTLE_CYCLES   = 25000,
  parameter logic [31:0] F_MIN           = FMinDef,
  parameter logic [31:0] F_MAX           = FMaxDef,
  parameter logic [31:0] F_STEP          = FStepDef,
  parameter logic [31:0] F_RESET         = FResetDef
) (
  input  logic        clk_25m,
  input  logic        reset,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_center,
  output logic [31:0] cw_freq,
  output logic        freq_strobe,
  output logic        mute,
  output logic        busy,
  output logic [1:0]  preset_idx
);

  localparam int unsigned TmrMax = (MUTE_CYCLES > SETTLE_CYCLES) ? MUTE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TmrW   = (TmrMax > 1) ? $clog2(TmrMax) : 1;
  localparam int unsigned LongW  = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;

  logic up_press, down_press, ctr_press;
  logic up_level, down_level, ctr_level;
  logic unused_levels;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk(clk_25m), .reset(reset), .btn_raw(btn_up), .level(up_level), .press(up_press)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk(clk_25m), .reset(reset), .btn_raw(btn_down), .level(down_level), .press(down_press)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_center (
    .clk(clk_25m), .reset(reset), .btn_raw(btn_center), .level(ctr_level), .press(ctr_press)
  );

  assign unused_levels = up_level ^ down_level;

  state_e           state_q, state_d;
  logic [TmrW-1:0]  tmr_q, tmr_d;
  logic [LongW-1:0] long_cnt_q, long_cnt_d;
  logic             c_active_q, c_active_d;
  logic [31:0]      target_q, target_d, cw_q, cw_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0][31:0] presets_q, presets_d;
  logic             req;

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    long_cnt_d = long_cnt_q;
    c_active_d = c_active_q;
    target_d   = target_q;
    cw_d       = cw_q;
    idx_d      = idx_q;
    presets_d  = presets_q;
    req        = 1'b0;
    unique case (state_q)
      StIdle: begin
        // long_cnt counts held cycles including the accept cycle.
        if (c_active_q) begin
          if (!ctr_level) begin
            c_active_d = 1'b0;
            idx_d      = idx_q + 2'd1;
            target_d   = presets_q[idx_q + 2'd1];
            req        = 1'b1;
          end else if (long_cnt_q == LongW'(LONG_CYCLES - 1)) begin
            c_active_d       = 1'b0;
            presets_d[idx_q] = cw_q;
          end else begin
            long_cnt_d = long_cnt_q + 1'b1;
          end
        end
        if (ctr_press) begin
          c_active_d = 1'b1;
          long_cnt_d = LongW'(1);
        end
        // A center short-press outranks up/down; simultaneous up+down cancels out.
        if (!req && (up_press ^ down_press)) begin
          target_d = step_freq(cw_q, up_press, F_MIN, F_MAX, F_STEP);
          req      = 1'b1;
        end
        if (req) begin
          state_d    = StMute;
          tmr_d      = '0;
          c_active_d = 1'b0;
        end
      end
      StMute: begin
        if (tmr_q == TmrW'(MUTE_CYCLES - 1)) begin
          state_d = StTune;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      StTune: begin
        cw_d    = target_q;
        state_d = StSettle;
        tmr_d   = '0;
      end
      StSettle: begin
        if (tmr_q == TmrW'(SETTLE_CYCLES - 1)) state_d = StIdle;
        else                                   tmr_d   = tmr_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase
    if (state_q != StIdle) c_active_d = 1'b0;
  end

  always_ff @(posedge clk_25m) begin
    if (reset) begin
      state_q    <= StIdle;
      tmr_q      <= '0;
      long_cnt_q <= '0;
      c_active_q <= 1'b0;
      target_q   <= F_RESET;
      cw_q       <= F_RESET;
      idx_q      <= 2'd0;
      presets_q  <= PresetReset;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      long_cnt_q <= long_cnt_d;
      c_active_q <= c_active_d;
      target_q   <= target_d;
      cw_q       <= cw_d;
      idx_q      <= idx_d;
      presets_q  <= presets_d;
    end
  end

  assign cw_freq     = cw_q;
  assign preset_idx  = idx_q;
  assign freq_strobe = (state_q == StTune);
  assign busy        = (state_q != StIdle);
  assign mute        = busy;

endmodule

// File: tb/tb_fm_tuner.sv
// Self-checking bench for fm_tuner: vector table, hand-timed corner sequences and a
// randomized run against an event-level model of the tuner.
module tb_fm_tuner;

  localparam int OpUp = 0, OpDown = 1, OpCenter = 2, OpBoth = 3, OpGlitch = 4;
  localparam int LongHold = 20;
  localparam logic [31:0] FMin = 32'd8750000, FMax = 32'd10800000;
  localparam logic [31:0] FStep = 32'd10000, FReset = 32'd10000000;

  logic        clk = 1'b0, reset = 1'b1;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_center = 1'b0;
  logic [31:0] cw_freq;
  logic        freq_strobe, mute, busy;
  logic [1:0]  preset_idx;

  fm_tuner #(
    .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .MUTE_CYCLES(3), .SETTLE_CYCLES(5)
  ) dut (
    .clk_25m(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
    .btn_center(btn_center), .cw_freq(cw_freq), .freq_strobe(freq_strobe), .mute(mute),
    .busy(busy), .preset_idx(preset_idx)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int strobe_cnt = 0, mute_cnt = 0, busy_cnt = 0, band_bad = 0, change_bad = 0;
  logic [31:0] prev_cw = FReset;
  logic        prev_strobe = 1'b0, prev_reset = 1'b1;

  // Cumulative event counters plus invariant watchers, sampled mid-cycle.
  always @(negedge clk) begin
    strobe_cnt  <= strobe_cnt + int'(freq_strobe);
    mute_cnt    <= mute_cnt + int'(mute);
    busy_cnt    <= busy_cnt + int'(busy);
    if (cw_freq < FMin || cw_freq > FMax) band_bad <= band_bad + 1;
    if (cw_freq !== prev_cw && !prev_strobe && !prev_reset) change_bad <= change_bad + 1;
    prev_cw     <= cw_freq;
    prev_strobe <= freq_strobe;
    prev_reset  <= reset;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (20) @(posedge clk);
  endtask

  task automatic apply_op(input int op, input int hold, output int ds, output int dm,
                          output int db);
    int s0, m0, b0;
    @(negedge clk);
    s0 = strobe_cnt; m0 = mute_cnt; b0 = busy_cnt;
    @(posedge clk); #1;
    case (op)
      OpUp:     btn_up = 1'b1;
      OpDown:   btn_down = 1'b1;
      OpCenter: btn_center = 1'b1;
      OpBoth:   begin btn_up = 1'b1; btn_down = 1'b1; end
      default:  btn_down = 1'b1;
    endcase
    repeat (hold) @(posedge clk);
    #1 btn_up = 1'b0; btn_down = 1'b0; btn_center = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    ds = strobe_cnt - s0; dm = mute_cnt - m0; db = busy_cnt - b0;
  endtask

  typedef struct {
    int          op;
    int          hold;
    logic [31:0] cw;
    int          idx;
    int          strobes;
  } vec_t;

  vec_t vecs[18];
  logic [31:0] m_p[4];
  logic [31:0] m_cw;
  int          m_idx;

  initial begin
    int ds, dm, db, s_k, s_n, m_first, m_n, b_n, b_last, s0, op, hold, exp_s;
    logic [31:0] cw_at, cw_after;

    vecs[0]  = '{OpUp,     8,  32'd10010000, 0, 1};
    vecs[1]  = '{OpDown,   8,  32'd10000000, 0, 1};
    vecs[2]  = '{OpCenter, 8,  32'd9500000,  1, 1};
    vecs[3]  = '{OpCenter, 19, 32'd10000000, 2, 1};
    vecs[4]  = '{OpUp,     8,  32'd10010000, 2, 1};
    vecs[5]  = '{OpCenter, 20, 32'd10010000, 2, 0};
    vecs[6]  = '{OpCenter, 8,  32'd10800000, 3, 1};
    vecs[7]  = '{OpUp,     8,  32'd8750000,  3, 1};
    vecs[8]  = '{OpDown,   8,  32'd10800000, 3, 1};
    vecs[9]  = '{OpBoth,   8,  32'd10800000, 3, 0};
    vecs[10] = '{OpGlitch, 2,  32'd10800000, 3, 0};
    vecs[11] = '{OpCenter, 8,  32'd8750000,  0, 1};
    vecs[12] = '{OpCenter, 8,  32'd9500000,  1, 1};
    vecs[13] = '{OpCenter, 8,  32'd10010000, 2, 1};
    vecs[14] = '{OpCenter, 30, 32'd10010000, 2, 0};
    vecs[15] = '{OpCenter, 8,  32'd10800000, 3, 1};
    vecs[16] = '{OpUp,     8,  32'd8750000,  3, 1};
    vecs[17] = '{OpCenter, 8,  32'd8750000,  0, 1};

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cw", cw_freq, FReset);
    check("rst_strobe", freq_strobe, 0);
    check("rst_mute", mute, 0);
    check("rst_busy", busy, 0);
    check("rst_idx", preset_idx, 0);
    #1 reset = 1'b0;
    repeat (20) @(posedge clk);

    // Up-press latency and mute window, counted from the raw press
    s_k = 0; s_n = 0; m_first = 0; m_n = 0; b_n = 0; cw_at = '0; cw_after = '0;
    @(posedge clk); #1 btn_up = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (k == 8) btn_up = 1'b0;
      @(negedge clk);
      if (freq_strobe) begin if (s_k == 0) s_k = k; s_n++; end
      if (mute) begin if (m_first == 0) m_first = k; m_n++; end
      if (busy) b_n++;
      if (k == 10) cw_at = cw_freq;
      if (k == 11) cw_after = cw_freq;
    end
    check("lat_strobe_cycle", s_k, 10);
    check("lat_strobe_count", s_n, 1);
    check("lat_mute_first", m_first, 7);
    check("lat_mute_len", m_n, 9);
    check("lat_busy_len", b_n, 9);
    check("lat_cw_in_tune", cw_at, FReset);
    check("lat_cw_after", cw_after, 32'd10010000);

    // Vector table from a fresh reset
    do_reset();
    foreach (vecs[i]) begin
      apply_op(vecs[i].op, vecs[i].hold, ds, dm, db);
      check($sformatf("vec%0d_cw", i), cw_freq, vecs[i].cw);
      check($sformatf("vec%0d_idx", i), preset_idx, vecs[i].idx);
      check($sformatf("vec%0d_strobes", i), ds, vecs[i].strobes);
      check($sformatf("vec%0d_mute", i), dm, 9 * vecs[i].strobes);
    end

    // Second up press accepted during SETTLE must be dropped
    do_reset();
    s_n = 0; b_n = 0; b_last = 0;
    @(posedge clk); #1 btn_up = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 4) btn_up = 1'b0;
      if (k == 8) btn_up = 1'b1;
      if (k == 16) btn_up = 1'b0;
      @(negedge clk);
      if (freq_strobe) s_n++;
      if (busy) begin b_n++; b_last = k; end
    end
    check("settle_strobes", s_n, 1);
    check("settle_busy_len", b_n, 9);
    check("settle_busy_last", b_last, 15);
    check("settle_cw", cw_freq, 32'd10010000);

    // Button held through reset release gives no press until re-pressed
    btn_up = 1'b1;
    do_reset();
    s0 = strobe_cnt;
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("held_rst_strobes", strobe_cnt - s0, 0);
    check("held_rst_cw", cw_freq, FReset);
    #1 btn_up = 1'b0;
    repeat (15) @(posedge clk);
    apply_op(OpUp, 8, ds, dm, db);
    check("held_rst_repress", ds, 1);
    check("held_rst_cw2", cw_freq, 32'd10010000);

    // Reset during MUTE aborts the retune
    s_n = 0; cw_at = '0; m_n = 1; b_n = 1;
    @(posedge clk); #1 btn_up = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (k == 8) reset = 1'b1;
      if (k == 10) btn_up = 1'b0;
      if (k == 11) reset = 1'b0;
      @(negedge clk);
      if (k == 8) check("abort_mute_before", mute, 1);
      if (k == 9) begin cw_at = cw_freq; m_n = mute; b_n = busy; end
      if (freq_strobe) s_n++;
    end
    check("abort_cw", cw_at, FReset);
    check("abort_mute", m_n, 0);
    check("abort_busy", b_n, 0);
    check("abort_strobes", s_n, 0);
    check("abort_cw_final", cw_freq, FReset);

    // Randomized operations against the event-level model
    do_reset();
    m_cw = FReset; m_idx = 0;
    m_p[0] = 32'd8750000; m_p[1] = 32'd9500000; m_p[2] = 32'd10000000; m_p[3] = 32'd10800000;
    for (int n = 0; n < 40; n++) begin
      op = int'($urandom_range(0, 4));
      case (op)
        OpCenter: hold = ($urandom_range(0, 1) == 1) ? int'($urandom_range(20, 28))
                                                     : int'($urandom_range(6, 19));
        OpGlitch: hold = int'($urandom_range(1, 3));
        default:  hold = int'($urandom_range(6, 12));
      endcase
      exp_s = 0;
      if (op == OpUp) begin
        m_cw = (m_cw == FMax) ? FMin : m_cw + FStep; exp_s = 1;
      end else if (op == OpDown) begin
        m_cw = (m_cw == FMin) ? FMax : m_cw - FStep; exp_s = 1;
      end else if (op == OpCenter) begin
        if (hold >= LongHold) m_p[m_idx] = m_cw;
        else begin m_idx = (m_idx + 1) % 4; m_cw = m_p[m_idx]; exp_s = 1; end
      end
      apply_op(op, hold, ds, dm, db);
      check($sformatf("rnd%0d_op%0d_cw", n, op), cw_freq, m_cw);
      check($sformatf("rnd%0d_op%0d_idx", n, op), preset_idx, m_idx);
      check($sformatf("rnd%0d_op%0d_strobes", n, op), ds, exp_s);
      check($sformatf("rnd%0d_op%0d_busy", n, op), db, 9 * exp_s);
    end

    check("inv_band", band_bad, 0);
    check("inv_change_without_strobe", change_bad, 0);
    check("inv_mute_eq_busy", mute_cnt, busy_cnt);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fm_tuner.md
FM_TUNER -- requirements
Module: fm_tuner

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
REQ-002 DEBOUNCE_CYCLES, 250000, stable-input cycles required to accept a button level (10 ms).
REQ-003 LONG_CYCLES, 25000000, hold time that turns a center press into a long press (1 s).
REQ-004 MUTE_CYCLES, 25000, mute lead time before a retune.
REQ-005 SETTLE_CYCLES, 25000, mute hold time after a retune.
REQ-006 F_MIN / F_MAX / F_STEP / F_RESET, 8750000 / 10800000 / 10000 / 10000000, band limits, step and reset frequency, all in 10 Hz units.
REQ-007 Ports SHALL be, one per line: name, direction, width, meaning.
REQ-008 clk_25m, in, 1, sole clock; all logic on its rising edge.
REQ-009 reset, in, 1, synchronous, active-high.
REQ-010 btn_up / btn_down / btn_center, in, 1 each, raw asynchronous buttons, active-high.
REQ-011 cw_freq, out, 32, carrier word for the FM transmitter, in 10 Hz units.
REQ-012 freq_strobe, out, 1, one-cycle pulse in the cycle cw_freq changes.
REQ-013 mute, out, 1, request to silence the PCM path.
REQ-014 busy, out, 1, high whenever the FSM is not in IDLE.
REQ-015 preset_idx, out, 2, currently selected preset slot.

Function
REQ-016 Each button SHALL pass a 2-flop synchronizer and then a debouncer; a press is the debounced 0->1 edge.
REQ-017 FSM states SHALL be IDLE, MUTE, TUNE, SETTLE.
REQ-018 In IDLE, an up press SHALL set target = cw_freq+F_STEP, or F_MIN when cw_freq = F_MAX (wrap).
REQ-019 In IDLE, a down press SHALL set target = cw_freq-F_STEP, or F_MAX when cw_freq = F_MIN (wrap).
REQ-020 Center released before LONG_CYCLES (short press) SHALL set preset_idx+1 (mod 4) and target = preset[new idx].
REQ-021 Center held LONG_CYCLES SHALL store cw_freq into preset[preset_idx] once; no retune, and the later release is ignored.
REQ-022 Any target request SHALL move the FSM IDLE->MUTE with mute=1; after MUTE_CYCLES, MUTE->TUNE.
REQ-023 TUNE SHALL last exactly 1 cycle: cw_freq<=target and freq_strobe=1 in that cycle; then TUNE->SETTLE.
REQ-024 SETTLE SHALL last SETTLE_CYCLES with mute=1, then ->IDLE with mute=0 in the first IDLE cycle.
REQ-025 Latency from the press-accept cycle to freq_strobe SHALL be MUTE_CYCLES+1 cycles.
REQ-026 Up and down pressed in the same cycle SHALL be ignored entirely.
REQ-027 Up or down in the same cycle as a center short-press event: center SHALL win.
REQ-028 Presses arriving while busy=1 SHALL be dropped, never queued; debouncers keep tracking during this time.
REQ-029 A target equal to cw_freq SHALL still run the full sequence.
REQ-030 cw_freq SHALL always lie within [F_MIN, F_MAX]; the arithmetic is 32-bit unsigned with no overflow possible.

Reset
REQ-031 Reset SHALL force: state IDLE, cw_freq=F_RESET, freq_strobe=0, mute=0, busy=0, preset_idx=0.
REQ-032 Reset SHALL load presets to {8750000, 9500000, 10000000, 10800000}.
REQ-033 Reset SHALL clear the synchronizers, debouncers and counters.
REQ-034 Reset asserted mid-sequence SHALL abort it; target is discarded and cw_freq returns to F_RESET on the next edge.
REQ-035 A button held through reset release SHALL NOT generate a press until it is released and pressed again.

Structure
REQ-036 Package fm_tuner_pkg SHALL hold the state enum, the band and step constants, and the preset reset table.
REQ-037 Sub-module btn_debounce (sync + counter + edge detect, parameter DEBOUNCE_CYCLES) SHALL be instantiated three times.
REQ-038 The long/short press timer and the FSM SHALL reside in fm_tuner.

Verification (DEBOUNCE=4, LONG=20, MUTE=3, SETTLE=5)
REQ-039 Reset, up press -> freq_strobe 4 cycles after accept; cw_freq 10000000->10010000; mute high for exactly 9 cycles.
REQ-040 Force cw_freq to 10800000 via presets, up press -> cw_freq 8750000; from 8750000 a down press -> 10800000.
REQ-041 A 2-cycle glitch on btn_down -> no press accepted, no strobe; up and down pressed together -> no retune.
REQ-042 Two center short presses -> preset_idx 2, cw_freq 10000000; hold up+step once, long center -> preset[2]=10010000, no strobe.
REQ-043 Up press, then a second up press during SETTLE -> only one step taken; busy deasserts after 9 cycles.
REQ-044 Reset asserted during MUTE -> next cycle cw_freq=10000000, mute=0, busy=0, no strobe.
